// File: rtl/dm_dump_unit.sv
// Debug readback engine: halts the CPU, reads a contiguous DM range and
// streams each byte out over a valid/ready interface.
module dm_dump_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_READ,
    S_SEND,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] span;
  logic              abort_pend;
  logic              abort_exit;

  assign span = last_addr - first_addr;

  always_comb begin
    state_nx  = state;
    halt_req  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    aborted   = 1'b0;
    dm_addr   = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_HALT;
      end
      S_HALT: begin
        halt_req = 1'b1;
        if (abort)         state_nx = S_FINISH;
        else if (halt_ack) state_nx = S_READ;
      end
      S_READ: begin
        halt_req = 1'b1;
        dm_addr  = ptr;
        state_nx = S_SEND;
      end
      S_SEND: begin
        halt_req  = 1'b1;
        out_valid = 1'b1;
        // Abort is only honoured at a beat boundary, i.e. on the handshake.
        if (out_ready) begin
          if (out_last || abort_pend || abort) state_nx = S_FINISH;
          else                                 state_nx = S_READ;
        end
      end
      S_FINISH: begin
        done     = 1'b1;
        aborted  = abort_exit;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      count      <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      out_last   <= 1'b0;
      abort_pend <= 1'b0;
      abort_exit <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr        <= first_addr;
            count      <= {1'b0, span} + CNT_ONE;
            out_last   <= 1'b0;
            abort_pend <= 1'b0;
            abort_exit <= 1'b0;
          end
        end
        S_HALT: begin
          if (abort) abort_exit <= 1'b1;
        end
        S_READ: begin
          out_data <= dm_rdata;
          out_addr <= ptr;
          out_last <= (count == CNT_ONE);
          if (abort) abort_pend <= 1'b1;
        end
        S_SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (out_ready) begin
            ptr        <= ptr + PTR_ONE;
            count      <= count - CNT_ONE;
            // An abort coinciding with the final beat still reports a clean finish.
            abort_exit <= !out_last && (abort_pend || abort);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dump_unit.sv
// Directed, table-driven bench for dm_dump_unit with a behavioural DM and CPU halt handshake.
module tb_dm_dump_unit;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] first_addr, last_addr;
  logic       halt_req, halt_ack;
  logic [7:0] dm_addr, dm_rdata;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data, out_addr;
  logic       busy, done, aborted;

  logic [7:0] dm [256];
  int         ack_mode;   // 0: never ack, 1: ack = halt_req delayed one cycle, 2: always high
  logic       ack_q = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ack_q <= halt_req;
  assign halt_ack = (ack_mode == 2) ? 1'b1 : (ack_mode == 1) ? ack_q : 1'b0;
  assign dm_rdata = dm[dm_addr];

  dm_dump_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy),
    .done(done), .aborted(aborted)
  );

  typedef struct {
    logic [7:0] f;
    logic [7:0] l;
    int         ack;
    bit         wrap_dm;
    logic [7:0] d50;
    int         abort_beat;  // -1 none, -2 held high from start
    int         stall_beat;
    int         stall_len;
    int         start_beat;
    int         exp_beats;
    logic [7:0] exp_d0;
    bit         exp_ab;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_dm(input bit wrap, input logic [7:0] d50);
    for (int i = 0; i < 256; i++) dm[i] = 8'(i) ^ 8'h5A;
    dm[0] = 8'd1; dm[1] = 8'd1; dm[2] = 8'd1; dm[3] = 8'd1; dm[4] = 8'd0; dm[5] = 8'd0;
    dm[50] = d50;
    if (wrap) begin
      dm[254] = 8'd7; dm[255] = 8'd8; dm[0] = 8'd9; dm[1] = 8'd10;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] q_data [$];
    logic [7:0] q_addr [$];
    logic       q_last [$];
    int         stalled = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] pd = '0;
    logic [7:0] pa = '0;
    bit         fin = 1'b0;
    logic       ab = 1'b0;
    int         full;
    logic [7:0] diff;
    set_dm(v.wrap_dm, v.d50);
    ack_mode = v.ack;
    @(negedge clk);
    start = 1'b1; first_addr = v.f; last_addr = v.l; out_ready = 1'b1;
    abort = (v.abort_beat == -2);
    @(negedge clk);
    start = 1'b0; first_addr = 8'd100; last_addr = 8'd120;
    for (int cyc = 0; cyc < 1200 && !fin; cyc++) begin
      int b;
      b = q_data.size();
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(out_data), 32'(pd));
        chk({tag, "_stall_addr"}, 32'(out_addr), 32'(pa));
      end
      out_ready = 1'b1;
      if (out_valid && b == v.stall_beat && stalled < v.stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end
      abort = (v.abort_beat == -2) || (out_valid && b == v.abort_beat);
      start = out_valid && (b == v.start_beat);
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pa = out_addr;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_addr.push_back(out_addr);
        q_last.push_back(out_last);
      end
      if (done) begin
        fin = 1'b1;
        ab  = aborted;
        chk({tag, "_fin_halt_req"}, 32'(halt_req), 32'd0);
        chk({tag, "_fin_valid"}, 32'(out_valid), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(fin), 32'd1);
    chk({tag, "_beats"}, 32'(q_data.size()), 32'(v.exp_beats));
    diff = v.l - v.f;
    full = int'(diff) + 1;
    for (int i = 0; i < q_data.size(); i++) begin
      logic [7:0] ea;
      ea = v.f + 8'(i);
      chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(ea));
      chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(dm[ea]));
      chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == full - 1));
    end
    if (q_data.size() > 0) chk({tag, "_first_data"}, 32'(q_data[0]), 32'(v.exp_d0));
    chk({tag, "_aborted"}, 32'(ab), 32'(v.exp_ab));
    @(negedge clk);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_halt"}, 32'(halt_req), 32'd0);
    chk({tag, "_post_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    //          f       l     ack wrap d50    abort stall slen start beats d0     ab
    tbl[0] = '{8'd0,   8'd5,   1, 0, 8'd0,   -1,   -1,   0,  -1,   6,   8'd1,   0}; // basic
    tbl[1] = '{8'd50,  8'd50,  1, 0, 8'd255, -1,   -1,   0,  -1,   1,   8'd255, 0}; // single 0xFF
    tbl[2] = '{8'd50,  8'd50,  1, 0, 8'd0,   -1,   -1,   0,  -1,   1,   8'd0,   0}; // single 0x00
    tbl[3] = '{8'd254, 8'd1,   1, 1, 8'd0,   -1,   -1,   0,  -1,   4,   8'd7,   0}; // wrap
    tbl[4] = '{8'd0,   8'd5,   1, 0, 8'd0,   -1,    1,   5,  -1,   6,   8'd1,   0}; // backpressure
    tbl[5] = '{8'd0,   8'd5,   1, 0, 8'd0,    2,   -1,   0,  -1,   3,   8'd1,   1}; // abort beat 3
    tbl[6] = '{8'd0,   8'd5,   1, 0, 8'd0,    5,   -1,   0,  -1,   6,   8'd1,   0}; // abort on last
    tbl[7] = '{8'd0,   8'd5,   1, 0, 8'd0,   -1,   -1,   0,   2,   6,   8'd1,   0}; // start mid
    tbl[8] = '{8'd0,   8'd255, 1, 0, 8'd0,   -1,   -1,   0,  -1, 256,   8'd1,   0}; // full 256
    tbl[9] = '{8'd0,   8'd5,   0, 0, 8'd0,   -2,   -1,   0,  -1,   0,   8'd0,   1}; // abort in HALT

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0; ack_mode = 1;
    set_dm(1'b0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    reset = 1'b0;

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);

    // Latency with halt_ack already high.
    ack_mode = 2;
    start = 1'b1; first_addr = 8'd3; last_addr = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("lat_halt_req", 32'(halt_req), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_valid_e0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_dm_addr", 32'(dm_addr), 32'd3);
    chk("lat_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_e2", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'd1);
    chk("lat_addr", 32'(out_addr), 32'd3);
    chk("lat_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_aborted", 32'(aborted), 32'd0);
    chk("lat_fin_halt", 32'(halt_req), 32'd0);
    @(negedge clk);
    chk("lat_busy_low", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset while stalled in SEND, then start coincident with reset.
    ack_mode = 1; out_ready = 1'b0;
    start = 1'b1; first_addr = 8'd0; last_addr = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("rst_mid_reached_send", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_halt_req", 32'(halt_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_out_data", 32'(out_data), 32'd0);
    chk("rst_mid_out_addr", 32'(out_addr), 32'd0);
    chk("rst_mid_out_last", 32'(out_last), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);
    out_ready = 1'b1;
    run_vec(tbl[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_dump_unit.md
Name: dm_dump_unit

Overview:
- Debug readback engine for the 8-bit computer's data memory (DM, 256 x 8).
- On command, it halts the CPU and reads a contiguous DM address range. It then streams each byte out over a valid/ready interface, and releases the CPU when the range is finished.
- It is the hardware counterpart of program/data loading: it extracts results (e.g. the compiled program's `result` at DM[4]) without hierarchical access.

Parameters:
- ADDR_W, 8, DM address width (DM depth = 2^ADDR_W).
- DATA_W, 8, DM word width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- first_addr  in  ADDR_W  first DM address; sampled when start is accepted.
- last_addr  in  ADDR_W  last DM address, inclusive; sampled when start is accepted.
- abort  in  1  request early termination.
- halt_req  out  1  asks the CPU to freeze its PC and block DM writes.
- halt_ack  in  1  CPU is frozen; held high while halt_req is high.
- dm_addr  out  ADDR_W  DM read address (DM read is combinational, same cycle).
- dm_rdata  in  DATA_W  DM read data.
- out_valid  out  1  out_data/out_addr/out_last are valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_data  out  DATA_W  dumped byte.
- out_addr  out  ADDR_W  DM address of out_data.
- out_last  out  1  final beat of the transfer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at transfer end.
- aborted  out  1  valid with done; 1 if the transfer ended by abort.

Behaviour:
- **Reset values.** State IDLE; halt_req, out_valid, out_last, busy, done and aborted are 0; dm_addr, out_data and out_addr are 0. Reset mid-transfer drops halt_req on the next edge with no done pulse.
- **Beat count.** count = ((last_addr - first_addr) mod 2^ADDR_W) + 1, giving 1..256 beats. first_addr > last_addr wraps 255 -> 0. first_addr == last_addr gives exactly one beat. The count register is ADDR_W+1 bits wide.
- **IDLE state.** On start: latch the addresses and count, set ptr = first_addr, then go to HALT. busy rises on the same edge.
- **HALT state.**
  - halt_req = 1.
  - Wait for halt_ack = 1, with no timeout, then go to READ.
  - abort here goes to FINISH.
- **READ state** (one cycle).
  - dm_addr = ptr.
  - Capture dm_rdata into out_data and ptr into out_addr.
  - out_last = (count == 1); out_valid = 1 from the next cycle.
  - Go to SEND.
- **SEND state.**
  - Hold out_* stable while out_valid && !out_ready. out_valid never drops without a handshake.
  - On handshake: ptr += 1 (mod 2^ADDR_W) and count -= 1.
    - If out_last, or abort is sampled high on or before the handshake cycle, go to FINISH.
    - Otherwise go to READ.
  - Throughput is 1 beat per 2 cycles, and abort is honoured only at beat boundaries.
- **FINISH state** (one cycle).
  - halt_req = 0, out_valid = 0, done = 1.
  - aborted = 1 if abort caused the exit, otherwise 0.
  - Go to IDLE; busy drops on the following edge.
- **Latency.** Start accepted at edge 0 -> halt_req high after edge 0. With halt_ack already high, READ runs after edge 1 and the first out_valid appears after edge 2.
- **halt_ack handling.** halt_ack must stay high from HALT until FINISH. A drop of halt_ack in READ/SEND is ignored; the CPU contract forbids it.
- **Simultaneous events.**
  - start while busy is ignored.
  - start together with reset: reset wins.
  - abort in IDLE has no effect.
  - abort together with the out_last handshake gives aborted = 0.
- While halted, DM contents are stable; the dump reflects DM at halt time.

Test Plan:
- **Basic range.** Preload DM[0..5] = 1,1,1,1,0,0; start with first=0, last=5, out_ready=1, halt_ack tied to halt_req delayed 1 cycle -> 6 beats: data 1,1,1,1,0,0, addr 0..5, out_last on beat 6 only. Then done = 1, aborted = 0, halt_req low, busy low the next cycle.
- **Single beat, single-bit patterns.** DM[50] = 255; first = last = 50 -> exactly 1 beat, out_data = 255, out_last = 1. Repeat with DM[50] = 0 -> out_data = 0.
- **Wrap-around.** DM[254] = 7, DM[255] = 8, DM[0] = 9, DM[1] = 10; first = 254, last = 1 -> 4 beats in order 7,8,9,10 with addr 254,255,0,1. Also first = 0, last = 255 -> 256 beats.
- **Backpressure.** out_ready low for 5 cycles on beat 2 of the 0..5 dump -> out_valid, out_data and out_addr stable throughout, no beat lost or duplicated, total stays 6 beats.
- **Abort cases.**
  - Abort asserted during beat 3 of the 0..5 dump -> beat 3 completes, then done = 1, aborted = 1, halt_req low, no beat 4.
  - Abort during HALT with halt_ack = 0 -> done with aborted = 1 and zero beats.
- **Protocol edges.**
  - start pulsed mid-transfer -> ignored; the original range completes.
  - reset asserted in SEND -> next cycle all outputs are at reset values and no done pulse; a new start then works normally.
